exec_fsm: RTL and testbench

Execute/decode control FSM sitting directly downstream of the instruction fetch FSM. The top level pulses start after the fetch FSM's done; the opcode is then already in IR. The block sequences MAR/MDR/memory/ACC/PC control strobes for one instruction, then pulses done so the top can start the next fetch. It uses the same bus, MAR, MDR and bmem EN/RW/MFC handshake as fetch.

---
 rtl/exec_fsm.sv | 248 ++++++++++++++++++++++++
 tb/tb_exec_fsm.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_fsm.sv
`default_nettype none
// ============================================================================
// Module   : exec_fsm
// Purpose  : Execute/decode control FSM. It runs after the instruction fetch
//            FSM has placed the opcode in IR. It steps through the
//            MAR/MDR/memory/ACC/PC control strobes for one instruction, then
//            pulses done so the top level can start the next fetch.
// Ports    : clk, reset (async, active-low)
//            start, ir_op[OPW], zero, MFC                        -> inputs
//            busy, done, halted, illegal, mem_fault              -> status
//            ir_addr_enable, mar_load, mdr_load_mem, mdr_load_bus,
//            mdr_enable_bus, mem_EN, mem_RW, acc_load, acc_enable_bus,
//            alu_add, alu_sub, pc_load                           -> strobes
// Options  : `define EXEC_MFC_TIMEOUT_EN adds a watchdog on the memory wait
//            states. It aborts the instruction and raises mem_fault when
//            MFC_TIMEOUT cycles pass without MFC.
// Revision : 1.0 - initial release
// ============================================================================
module exec_fsm #(
    parameter int OPW         = 4,
    parameter int MFC_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] ir_op,
    input  logic           zero,
    input  logic           MFC,
    output logic           busy,
    output logic           done,
    output logic           halted,
    output logic           illegal,
    output logic           mem_fault,
    output logic           ir_addr_enable,
    output logic           mar_load,
    output logic           mdr_load_mem,
    output logic           mdr_load_bus,
    output logic           mdr_enable_bus,
    output logic           mem_EN,
    output logic           mem_RW,
    output logic           acc_load,
    output logic           acc_enable_bus,
    output logic           alu_add,
    output logic           alu_sub,
    output logic           pc_load
);

    localparam logic [OPW-1:0] c_OP_NOP   = OPW'(0);
    localparam logic [OPW-1:0] c_OP_LOAD  = OPW'(1);
    localparam logic [OPW-1:0] c_OP_STORE = OPW'(2);
    localparam logic [OPW-1:0] c_OP_ADD   = OPW'(3);
    localparam logic [OPW-1:0] c_OP_SUB   = OPW'(4);
    localparam logic [OPW-1:0] c_OP_JMP   = OPW'(5);
    localparam logic [OPW-1:0] c_OP_JZ    = OPW'(6);
    localparam logic [OPW-1:0] c_OP_HALT  = OPW'(7);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DECODE   = 4'd1,
        S_ADDR2MAR = 4'd2,
        S_RD_START = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_MDR2ACC  = 4'd5,
        S_ACC2MDR  = 4'd6,
        S_WR_START = 4'd7,
        S_WR_WAIT  = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd10,
        S_DONE     = 4'd11
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] r_op;
    logic           r_illegal;
    logic           w_set_illegal;
    logic           w_in_wait;
    logic           w_timeout;

    assign w_in_wait = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);

`ifdef EXEC_MFC_TIMEOUT_EN
    localparam int CW = $clog2(MFC_TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_mem_fault;

    // The counter reads 0 on the first wait cycle. When it reaches
    // MFC_TIMEOUT-1, the wait state has lasted MFC_TIMEOUT cycles. MFC is
    // checked first, so an MFC on that same cycle still completes normally.
    assign w_timeout = w_in_wait && (r_cnt == CW'(MFC_TIMEOUT - 1));
    assign mem_fault = r_mem_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_cnt <= w_in_wait ? r_cnt + 1'b1 : '0;
            if (w_timeout && !MFC) begin
                r_mem_fault <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (MFC_TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign mem_fault        = 1'b0;
`endif

    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= ir_op;
            end
            if (r_state == S_IDLE && start) begin
                r_illegal <= 1'b0;
            end else if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_set_illegal  = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        ir_addr_enable = 1'b0;
        mar_load       = 1'b0;
        mdr_load_mem   = 1'b0;
        mdr_load_bus   = 1'b0;
        mdr_enable_bus = 1'b0;
        mem_EN         = 1'b0;
        mem_RW         = 1'b0;
        acc_load       = 1'b0;
        acc_enable_bus = 1'b0;
        alu_add        = 1'b0;
        alu_sub        = 1'b0;
        pc_load        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    busy   = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // The decision uses ir_op directly. r_op takes the value at
                // the end of this cycle and is used for the rest of the
                // instruction.
                busy = 1'b1;
                case (ir_op)
                    c_OP_NOP:   w_next = S_DONE;
                    c_OP_LOAD,
                    c_OP_STORE,
                    c_OP_ADD,
                    c_OP_SUB:   w_next = S_ADDR2MAR;
                    c_OP_JMP:   w_next = S_JUMP;
                    c_OP_JZ:    w_next = zero ? S_JUMP : S_DONE;
                    c_OP_HALT:  w_next = S_HALT;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_next        = S_DONE;
                    end
                endcase
            end
            S_ADDR2MAR: begin
                busy           = 1'b1;
                ir_addr_enable = 1'b1;
                mar_load       = 1'b1;
                w_next         = (r_op == c_OP_STORE) ? S_ACC2MDR : S_RD_START;
            end
            S_RD_START: begin
                busy   = 1'b1;
                mem_EN = 1'b1;
                mem_RW = 1'b1;
                w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                busy   = 1'b1;
                mem_EN = 1'b1;
                mem_RW = 1'b1;
                if (MFC) begin
                    mdr_load_mem = 1'b1;
                    w_next       = S_MDR2ACC;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_MDR2ACC: begin
                busy           = 1'b1;
                mdr_enable_bus = 1'b1;
                acc_load       = (r_op == c_OP_LOAD);
                alu_add        = (r_op == c_OP_ADD);
                alu_sub        = (r_op == c_OP_SUB);
                w_next         = S_DONE;
            end
            S_ACC2MDR: begin
                busy           = 1'b1;
                acc_enable_bus = 1'b1;
                mdr_load_bus   = 1'b1;
                w_next         = S_WR_START;
            end
            S_WR_START: begin
                busy   = 1'b1;
                mem_EN = 1'b1;
                w_next = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                busy   = 1'b1;
                mem_EN = 1'b1;
                if (MFC || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_JUMP: begin
                busy           = 1'b1;
                ir_addr_enable = 1'b1;
                pc_load        = 1'b1;
                w_next         = S_DONE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_fsm
// Purpose  : Self-checking bench for exec_fsm. For each instruction, the
//            expected per-cycle output vectors are queued when the stimulus
//            is set up. They are then popped and compared against the DUT
//            one cycle at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_fsm;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] ir_op = 4'd0;
    logic       zero  = 1'b0;
    logic       MFC   = 1'b0;

    wire busy, done, halted, illegal, mem_fault;
    wire ir_addr_enable, mar_load, mdr_load_mem, mdr_load_bus, mdr_enable_bus;
    wire mem_EN, mem_RW, acc_load, acc_enable_bus, alu_add, alu_sub, pc_load;

    exec_fsm #(.OPW(4), .MFC_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .ir_op(ir_op), .zero(zero),
        .MFC(MFC), .busy(busy), .done(done), .halted(halted),
        .illegal(illegal), .mem_fault(mem_fault),
        .ir_addr_enable(ir_addr_enable), .mar_load(mar_load),
        .mdr_load_mem(mdr_load_mem), .mdr_load_bus(mdr_load_bus),
        .mdr_enable_bus(mdr_enable_bus), .mem_EN(mem_EN), .mem_RW(mem_RW),
        .acc_load(acc_load), .acc_enable_bus(acc_enable_bus),
        .alu_add(alu_add), .alu_sub(alu_sub), .pc_load(pc_load)
    );

    always #5 clk = ~clk;

    // Output vector bit positions
    localparam logic [16:0] FLT  = 17'h10000;
    localparam logic [16:0] HLT  = 17'h08000;
    localparam logic [16:0] ILL  = 17'h04000;
    localparam logic [16:0] BSY  = 17'h02000;
    localparam logic [16:0] DN   = 17'h01000;
    localparam logic [16:0] IRA  = 17'h00800;
    localparam logic [16:0] MARL = 17'h00400;
    localparam logic [16:0] MDRM = 17'h00200;
    localparam logic [16:0] MDRB = 17'h00100;
    localparam logic [16:0] MDRE = 17'h00080;
    localparam logic [16:0] MEN  = 17'h00040;
    localparam logic [16:0] MRW  = 17'h00020;
    localparam logic [16:0] ACCL = 17'h00010;
    localparam logic [16:0] ACCE = 17'h00008;
    localparam logic [16:0] ADD  = 17'h00004;
    localparam logic [16:0] SUB  = 17'h00002;
    localparam logic [16:0] PCL  = 17'h00001;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] sb[$];
    bit          m_illegal = 1'b0;
    bit          m_fault   = 1'b0;

    function automatic logic [16:0] obs();
        return {mem_fault, halted, illegal, busy, done, ir_addr_enable,
                mar_load, mdr_load_mem, mdr_load_bus, mdr_enable_bus, mem_EN,
                mem_RW, acc_load, acc_enable_bus, alu_add, alu_sub, pc_load};
    endfunction

    task automatic push(input logic [16:0] v);
        sb.push_back(v | (m_fault ? FLT : 17'h0) | (m_illegal ? ILL : 17'h0));
    endtask

    // Reference model. It queues one expected vector per cycle, starting with
    // the cycle in which start is sampled (cycle 0).
    task automatic model(input logic [3:0] op, input bit z, input int k, input bit tmo);
        push(BSY);            // IDLE with start; illegal still shows old value
        m_illegal = 1'b0;
        push(BSY);            // DECODE
        if (op == 4'd0 || (op == 4'd6 && !z)) begin
            push(DN);
        end else if (op >= 4'd8) begin
            m_illegal = 1'b1;
            push(DN);
        end else if (op == 4'd5 || op == 4'd6) begin
            push(BSY | IRA | PCL);
            push(DN);
        end else if (op == 4'd7) begin
            repeat (8) push(HLT);
        end else if (op == 4'd2) begin
            push(BSY | IRA | MARL);
            push(BSY | ACCE | MDRB);
            push(BSY | MEN);                  // WR_START
            repeat (k + 1) push(BSY | MEN);   // WR_WAIT
            push(DN);
        end else begin
            push(BSY | IRA | MARL);
            push(BSY | MEN | MRW);            // RD_START
            if (tmo) begin
                repeat (4) push(BSY | MEN | MRW);
                m_fault = 1'b1;
                push(DN);
            end else begin
                repeat (k) push(BSY | MEN | MRW);
                push(BSY | MEN | MRW | MDRM);
                push(BSY | MDRE | ((op == 4'd1) ? ACCL : (op == 4'd3) ? ADD : SUB));
                push(DN);
            end
        end
        if (op != 4'd7) push(17'h0);          // back in IDLE
    endtask

    // Run one instruction against the queued expectations.
    //   k     : MFC arrives k cycles after entering the wait state
    //   hold  : MFC held high for the whole instruction
    //   sd    : pulse start during the DONE cycle (must be ignored)
    //   hst   : pulse start while halted (must be ignored)
    //   tmo   : expect the wait watchdog to fire (MFC never sent)
    task automatic run(input logic [3:0] op, input bit z, input int k, input bit hold,
                       input bit sd, input bit hst, input bit tmo, input string name);
        int          exp_done;
        int          obs_done;
        int          c;
        int          wait_entry;
        logic [16:0] expv;
        logic [16:0] got;
        exp_done   = -1;
        obs_done   = -1;
        c          = 0;
        wait_entry = (op == 4'd2) ? 5 : 4;
        model(op, z, k, tmo);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i][12] && exp_done < 0) exp_done = i;
        end
        while (sb.size() > 0) begin
            expv = sb.pop_front();
            @(posedge clk);
            #1;
            start = (c == 0) || (sd && expv[12]) || (hst && c >= 3 && (c % 2) == 1);
            ir_op = (c <= 1) ? op : 4'(c * 5 + 3);
            zero  = (c <= 1) ? z : ~z;
            MFC   = hold || (!tmo && c == wait_entry + k);
            @(negedge clk);
            got = obs();
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs %h, expected %h", name, c, got, expv);
            end
            if (got[12] && obs_done < 0) obs_done = c;
            c++;
        end
        start = 1'b0;
        MFC   = 1'b0;
        n_tests++;
        if (obs_done !== exp_done) begin
            n_fail++;
            $display("FAIL %s done cycle: got %0d, expected %0d", name, obs_done, exp_done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs() !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_state: outputs %h, expected 0", obs());
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs() !== 17'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: outputs %h, expected 0", obs());
        end
    endtask

    task automatic test_nop_illegal();
        run(4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "nop");
        run(4'd9, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "illegal9");
        run(4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "nop_clears_illegal");
        run(4'd15, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "illegal15");
    endtask

    task automatic test_load();
        run(4'd1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, "load_mfc3");
        run(4'd1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "load_mfc_held");
    endtask

    task automatic test_store();
        run(4'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "store_mfc0");
        run(4'd2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, "store_mfc2");
        run(4'd2, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "store_mfc_held");
    endtask

    task automatic test_jumps();
        run(4'd6, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "jz_taken");
        run(4'd6, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "jz_not_taken");
        run(4'd5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "jmp");
    endtask

    task automatic test_back_to_back();
        run(4'd3, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, "add_start_in_done");
        run(4'd4, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "sub_back_to_back");
        run(4'd4, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, "sub_mfc5");
    endtask

    task automatic test_halt();
        run(4'd7, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, "halt");
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (obs() !== 17'h0) begin
            n_fail++;
            $display("FAIL halt_reset: outputs %h, expected 0", obs());
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk);
        #1;
        start = 1'b1;
        ir_op = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);  // now in cycle 5, inside RD_WAIT
        #1;
        n_tests++;
        if (mem_EN !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_wait_before_reset: mem_EN %b busy %b, expected 1 1", mem_EN, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (obs() !== 17'h0) begin
            n_fail++;
            $display("FAIL async_abort: outputs %h, expected 0", obs());
        end
        m_illegal = 1'b0;
        m_fault   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run(4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "nop_after_abort");
    endtask

`ifdef EXEC_MFC_TIMEOUT_EN
    task automatic test_timeout();
        run(4'd4, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "sub_timeout");
        run(4'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "fault_sticky");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nop_illegal();
        test_load();
        test_store();
        test_jumps();
        test_back_to_back();
        test_halt();
        test_reset_mid_op();
`ifdef EXEC_MFC_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
